// File: rtl/hc595_frame_rx_if.sv
// Serial 74HC595 link lines plus the received-word outputs of the frame receiver.
interface hc595_frame_rx_if #(
    parameter int DATA_W = 16
);
    logic              SH_CP;
    logic              ST_CP;
    logic              DS;
    logic [DATA_W-1:0] Data;
    logic              Data_valid;
    logic              Frame_err;
    logic              Busy;

    // Transmitter / consumer side: drives the serial lines, observes the received word.
    modport master (
        output SH_CP, ST_CP, DS,
        input  Data, Data_valid, Frame_err, Busy
    );

    // Receiver side.
    modport slave (
        input  SH_CP, ST_CP, DS,
        output Data, Data_valid, Frame_err, Busy
    );
endinterface

// File: rtl/hc595_frame_rx.sv
// 74HC595 serial frame receiver: oversampled SH_CP/ST_CP/DS, MSB-first shift, word out on ST_CP rise.
// Data_valid SYNC_STAGES+1 Clk after ST_CP pin rise (+2 with HC595_RX_GLITCH_FILTER_EN defined).
// No backpressure: the link is free-running, each ST_CP rise yields Data_valid or Frame_err.
module hc595_frame_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_MAX = 255
) (
    input  logic               Clk,
    input  logic               Reset_n,
    hc595_frame_rx_if.slave    bus
);
    localparam int CW = $clog2(DATA_W + 2);
    localparam int TW = (TIMEOUT_MAX > 0) ? $clog2(TIMEOUT_MAX + 1) : 1;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sh_sync_q, st_sync_q, ds_sync_q;
    logic                   sh_sync, st_sync, ds_sync;
    logic                   sh_lvl, st_lvl, ds_s;
    logic                   sh_lvl_q, st_lvl_q;
    logic                   sh_rise, st_rise;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_n;
    logic [TW-1:0]          tmo_q, tmo_d, tmo_inc;
    logic [DATA_W-1:0]      sh_q, sh_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   vld_q, vld_d;
    logic                   err_q, err_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_sync_q <= '0;
            st_sync_q <= '0;
            ds_sync_q <= '0;
        end else begin
            sh_sync_q <= {sh_sync_q[SYNC_STAGES-2:0], bus.SH_CP};
            st_sync_q <= {st_sync_q[SYNC_STAGES-2:0], bus.ST_CP};
            ds_sync_q <= {ds_sync_q[SYNC_STAGES-2:0], bus.DS};
        end
    end

    assign sh_sync = sh_sync_q[SYNC_STAGES-1];
    assign st_sync = st_sync_q[SYNC_STAGES-1];
    assign ds_sync = ds_sync_q[SYNC_STAGES-1];

`ifdef HC595_RX_GLITCH_FILTER_EN
    logic [1:0] sh_hist_q, st_hist_q, ds_hist_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_hist_q <= '0;
            st_hist_q <= '0;
            ds_hist_q <= '0;
        end else begin
            sh_hist_q <= {sh_hist_q[0], sh_sync};
            st_hist_q <= {st_hist_q[0], st_sync};
            ds_hist_q <= {ds_hist_q[0], ds_sync};
        end
    end

    // Level follows the line only once the current and two previous samples agree.
    assign sh_lvl = (sh_sync == sh_hist_q[0] && sh_sync == sh_hist_q[1]) ? sh_sync : sh_lvl_q;
    assign st_lvl = (st_sync == st_hist_q[0] && st_sync == st_hist_q[1]) ? st_sync : st_lvl_q;
    assign ds_s   = ds_hist_q[1];
`else
    assign sh_lvl = sh_sync;
    assign st_lvl = st_sync;
    assign ds_s   = ds_sync;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_lvl_q <= 1'b0;
            st_lvl_q <= 1'b0;
        end else begin
            sh_lvl_q <= sh_lvl;
            st_lvl_q <= st_lvl;
        end
    end

    assign sh_rise = sh_lvl & ~sh_lvl_q;
    assign st_rise = st_lvl & ~st_lvl_q;
    assign tmo_inc = tmo_q + TW'(1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        cnt_n  = cnt_q;
        sh_d   = sh_q;
        tmo_d  = '0;
        data_d = data_q;
        vld_d  = 1'b0;
        err_d  = 1'b0;

        if (sh_rise) begin
            sh_d = {sh_q[DATA_W-2:0], ds_s};
            if (cnt_q != CW'(DATA_W + 1))
                cnt_n = cnt_q + CW'(1);
        end
        cnt_d = cnt_n;

        // A strobe judges the count after any shift in the same cycle.
        if (st_rise) begin
            if (cnt_n == CW'(DATA_W)) begin
                data_d = sh_d;
                vld_d  = 1'b1;
            end else begin
                err_d  = 1'b1;
            end
            cnt_d = '0;
        end else if (state_q == S_SHIFT && !sh_rise && TIMEOUT_MAX != 0) begin
            if (tmo_inc == TW'(TIMEOUT_MAX)) begin
                err_d = 1'b1;
                cnt_d = '0;
            end else begin
                tmo_d = tmo_inc;
            end
        end

        state_d = (cnt_d != '0) ? S_SHIFT : S_IDLE;
    end

    always_comb begin
        bus.Data       = data_q;
        bus.Data_valid = vld_q;
        bus.Frame_err  = err_q;
        bus.Busy       = (state_q == S_SHIFT);
    end
endmodule
